return_pop_sequencer: RTL and testbench

- Return-path reader for the CPU call stack.
- A call pushes the 16-bit PC onto the RAM stack as two bytes: pre-increment SP, write LSB, pre-increment SP, write MSB.
- This block is the matching reader. On a Start pulse it pops both bytes from the byte-wide RAM (MSB first), rebuilds the 16-bit return address and hands back the decremented SP for write-back into the SP register pair.
- It sits between the CPU control path, the register file SP pair and the RAM read port.

---
 rtl/return_pop_sequencer_pkg.sv | 25 ++
 rtl/return_pop_sequencer_if.sv | 27 ++
 rtl/return_pop_sequencer_ram_read_slot.sv | 46 ++++
 rtl/return_pop_sequencer.sv | 103 ++++++++++
 tb/tb_return_pop_sequencer.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/return_pop_sequencer_pkg.sv
// Shared call-stack definitions: pop sequencer states, SP register-pair indices,
// the empty-stack base shared with the push path, and the pop-legality rule.
package return_pop_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_MSB,
    ST_RD_LSB,
    ST_COMMIT,
    ST_FAULT
  } pop_state_e;

  localparam logic [4:0]  SP_LO_SEL          = 5'b10000;
  localparam logic [4:0]  SP_HI_SEL          = 5'b10001;
  localparam logic [15:0] STACK_BASE_DEFAULT = 16'h0100;

  // A return pop needs two bytes above the empty-stack base; 17-bit compare so
  // a base near the top of the address space cannot wrap the limit.
  function automatic logic pop_allowed(input logic [15:0] sp, input logic [15:0] base);
    logic [16:0] limit;
    limit = {1'b0, base} + 17'd2;
    return ({1'b0, sp} >= limit);
  endfunction

endpackage

// File: rtl/return_pop_sequencer_if.sv
// Control, stack-pointer and RAM read-port signals between the CPU control path
// and the return-address pop sequencer.
interface return_pop_sequencer_if;

  logic        start;
  logic [15:0] sp_in;
  logic [7:0]  ram_data;
  logic        busy;
  logic [15:0] ram_addr;
  logic        ram_re;
  logic [15:0] sp_out;
  logic        sp_we;
  logic [15:0] return_addr;
  logic        done;
  logic        underflow;

  modport master (
    output start, sp_in, ram_data,
    input  busy, ram_addr, ram_re, sp_out, sp_we, return_addr, done, underflow
  );

  modport slave (
    input  start, sp_in, ram_data,
    output busy, ram_addr, ram_re, sp_out, sp_we, return_addr, done, underflow
  );

endinterface

// File: rtl/return_pop_sequencer_ram_read_slot.sv
// One RAM byte read: holds the address for RAM_LATENCY+1 cycles and flags the
// cycle in which the read data is valid so the caller can capture it.
module return_pop_sequencer_ram_read_slot #(
  parameter int unsigned RAM_LATENCY = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        go_i,
  input  logic [15:0] addr_i,
  input  logic [7:0]  ram_data_i,
  output logic [15:0] ram_addr_o,
  output logic        ram_re_o,
  output logic [7:0]  byte_o,
  output logic        valid_o
);

  localparam logic [2:0] LAST_CNT = 3'(RAM_LATENCY);

  logic [2:0] cnt_q, cnt_d;

  // Counter wraps to 0 on the capture cycle so back-to-back reads restart cleanly.
  always_comb begin
    cnt_d   = '0;
    valid_o = 1'b0;
    if (go_i) begin
      if (cnt_q == LAST_CNT) begin
        valid_o = 1'b1;
      end else begin
        cnt_d = cnt_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign ram_addr_o = go_i ? addr_i : '0;
  assign ram_re_o   = go_i;
  assign byte_o     = ram_data_i;

endmodule

// File: rtl/return_pop_sequencer.sv
// Call-stack return path: pops MSB then LSB of the return address from RAM and
// hands back the address plus the decremented SP for the SP register pair.
module return_pop_sequencer
  import return_pop_sequencer_pkg::*;
#(
  parameter logic [15:0] STACK_BASE  = STACK_BASE_DEFAULT,
  parameter int unsigned RAM_LATENCY = 1
) (
  input logic                  clk_i,
  input logic                  rst_i,
  return_pop_sequencer_if.slave bus
);

  pop_state_e  state_q, state_d;
  logic [15:0] sp_q, sp_d;
  logic [7:0]  msb_q, msb_d;
  logic [15:0] ret_q, ret_d;
  logic [15:0] sp_out_q, sp_out_d;

  logic        slot_go;
  logic [15:0] slot_addr;
  logic [7:0]  slot_byte;
  logic        slot_valid;

  // One read slot serves both bytes; only the address differs per state.
  assign slot_go   = (state_q == ST_RD_MSB) || (state_q == ST_RD_LSB);
  assign slot_addr = (state_q == ST_RD_LSB) ? (sp_q - 16'd1) : sp_q;

  return_pop_sequencer_ram_read_slot #(
    .RAM_LATENCY(RAM_LATENCY)
  ) u_slot (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .go_i       (slot_go),
    .addr_i     (slot_addr),
    .ram_data_i (bus.ram_data),
    .ram_addr_o (bus.ram_addr),
    .ram_re_o   (bus.ram_re),
    .byte_o     (slot_byte),
    .valid_o    (slot_valid)
  );

  always_comb begin
    state_d  = state_q;
    sp_d     = sp_q;
    msb_d    = msb_q;
    ret_d    = ret_q;
    sp_out_d = sp_out_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if (pop_allowed(bus.sp_in, STACK_BASE)) begin
            sp_d    = bus.sp_in;
            state_d = ST_RD_MSB;
          end else begin
            state_d = ST_FAULT;
          end
        end
      end
      ST_RD_MSB: begin
        if (slot_valid) begin
          msb_d   = slot_byte;
          state_d = ST_RD_LSB;
        end
      end
      ST_RD_LSB: begin
        // Return address and new SP are registered here so both are stable in COMMIT.
        if (slot_valid) begin
          ret_d    = {msb_q, slot_byte};
          sp_out_d = sp_q - 16'd2;
          state_d  = ST_COMMIT;
        end
      end
      ST_COMMIT: state_d = ST_IDLE;
      ST_FAULT:  state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      sp_q     <= '0;
      msb_q    <= '0;
      ret_q    <= '0;
      sp_out_q <= '0;
    end else begin
      state_q  <= state_d;
      sp_q     <= sp_d;
      msb_q    <= msb_d;
      ret_q    <= ret_d;
      sp_out_q <= sp_out_d;
    end
  end

  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.done        = (state_q == ST_COMMIT) || (state_q == ST_FAULT);
  assign bus.sp_we       = (state_q == ST_COMMIT);
  assign bus.underflow   = (state_q == ST_FAULT);
  assign bus.sp_out      = sp_out_q;
  assign bus.return_addr = ret_q;

endmodule

// File: tb/tb_return_pop_sequencer.sv
// Bench for return_pop_sequencer: two instances (RAM latency 1 and 3) against
// a byte-array RAM and a per-cycle expected trace derived from the pop rules.
module tb_return_pop_sequencer;

  localparam logic [15:0] BASE = 16'h0100;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  return_pop_sequencer_if bus1 ();
  return_pop_sequencer_if bus3 ();

  return_pop_sequencer #(.STACK_BASE(BASE), .RAM_LATENCY(1)) u_dut_l1 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus1)
  );

  return_pop_sequencer #(.STACK_BASE(BASE), .RAM_LATENCY(3)) u_dut_l3 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus3)
  );

  // RAM: data for an address appears RAM_LATENCY edges after it is presented.
  logic [7:0] mem [0:65535];
  logic [7:0] l1_pipe;
  logic [7:0] l3_pipe [3];

  always @(posedge clk) begin
    l1_pipe    <= mem[bus1.ram_addr];
    l3_pipe[0] <= mem[bus3.ram_addr];
    l3_pipe[1] <= l3_pipe[0];
    l3_pipe[2] <= l3_pipe[1];
  end

  assign bus1.ram_data = l1_pipe;
  assign bus3.ram_data = l3_pipe[2];

  typedef struct packed {
    logic        busy;
    logic [15:0] addr;
    logic        re;
    logic [15:0] spout;
    logic        we;
    logic [15:0] ret;
    logic        done;
    logic        uf;
  } obs_t;

  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] last_ret [2];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic obs_t sample(input int lat);
    obs_t o;
    if (lat == 1) begin
      o = '{bus1.busy, bus1.ram_addr, bus1.ram_re, bus1.sp_out, bus1.sp_we,
            bus1.return_addr, bus1.done, bus1.underflow};
    end else begin
      o = '{bus3.busy, bus3.ram_addr, bus3.ram_re, bus3.sp_out, bus3.sp_we,
            bus3.return_addr, bus3.done, bus3.underflow};
    end
    return o;
  endfunction

  task automatic drive(input int lat, input logic s, input logic [15:0] sp);
    if (lat == 1) begin
      bus1.start = s;
      bus1.sp_in = sp;
    end else begin
      bus3.start = s;
      bus3.sp_in = sp;
    end
  endtask

  task automatic check_reset_state(input int lat);
    obs_t  o;
    string p;
    o = sample(lat);
    p = $sformatf("L%0d reset", lat);
    check_eq({p, " busy"},  32'(o.busy),  32'd0);
    check_eq({p, " addr"},  32'(o.addr),  32'd0);
    check_eq({p, " re"},    32'(o.re),    32'd0);
    check_eq({p, " spout"}, 32'(o.spout), 32'd0);
    check_eq({p, " we"},    32'(o.we),    32'd0);
    check_eq({p, " ret"},   32'(o.ret),   32'd0);
    check_eq({p, " done"},  32'(o.done),  32'd0);
    check_eq({p, " uf"},    32'(o.uf),    32'd0);
  endtask

  // One pop, checked cycle by cycle; with hold the start stays high throughout and
  // SP input moves to 0x0200, with chained the accept edge was set up by the caller.
  task automatic pop(input int lat, input logic [15:0] sp, input bit hold, input bit chained);
    int          idx;
    bit          ok;
    int          ncyc;
    logic [15:0] exp_ret;
    logic [15:0] exp_addr;
    obs_t        o;
    string       p;
    idx     = (lat == 1) ? 0 : 1;
    ok      = (32'(sp) >= 32'(BASE) + 32'd2);
    ncyc    = ok ? 2 * lat + 3 : 1;
    exp_ret = ok ? {mem[sp], mem[sp - 16'd1]} : last_ret[idx];
    if (!chained) drive(lat, 1'b1, sp);
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      o = sample(lat);
      p = $sformatf("L%0d sp%04h c%0d", lat, sp, c);
      check_eq({p, " busy"}, 32'(o.busy), 32'd1);
      check_eq({p, " re"},   32'(o.re),   32'(ok && c < ncyc));
      if (ok && c < ncyc) begin
        exp_addr = (c <= lat + 1) ? sp : sp - 16'd1;
        check_eq({p, " addr"}, 32'(o.addr), 32'(exp_addr));
      end
      check_eq({p, " done"}, 32'(o.done), 32'(c == ncyc));
      check_eq({p, " we"},   32'(o.we),   32'(ok && c == ncyc));
      check_eq({p, " uf"},   32'(o.uf),   32'(!ok && c == ncyc));
      check_eq({p, " ret"},  32'(o.ret),  32'((c < ncyc) ? last_ret[idx] : exp_ret));
      if (ok && c == ncyc) check_eq({p, " spout"}, 32'(o.spout), 32'(sp - 16'd2));
      if (c == 1 && !hold) drive(lat, 1'b0, sp);
      if (c == 2 && hold) drive(lat, 1'b1, 16'h0200);
    end
    last_ret[idx] = exp_ret;
    @(negedge clk);
    o = sample(lat);
    p = $sformatf("L%0d sp%04h idle", lat, sp);
    check_eq({p, " busy"}, 32'(o.busy), 32'd0);
    check_eq({p, " re"},   32'(o.re),   32'd0);
    check_eq({p, " done"}, 32'(o.done), 32'd0);
    check_eq({p, " we"},   32'(o.we),   32'd0);
    check_eq({p, " uf"},   32'(o.uf),   32'd0);
    check_eq({p, " ret"},  32'(o.ret),  32'(exp_ret));
    if (ok) check_eq({p, " spout"}, 32'(o.spout), 32'(sp - 16'd2));
  endtask

  task automatic reset_mid_pop();
    obs_t o;
    mem[16'h0150] = 8'h5A;
    mem[16'h014F] = 8'hA5;
    drive(1, 1'b1, 16'h0150);
    @(negedge clk);
    drive(1, 1'b0, 16'h0150);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    last_ret[0] = '0;
    last_ret[1] = '0;
    o = sample(1);
    check_eq("rstmid busy", 32'(o.busy), 32'd0);
    check_eq("rstmid re",   32'(o.re),   32'd0);
    check_eq("rstmid ret",  32'(o.ret),  32'd0);
    check_eq("rstmid done", 32'(o.done), 32'd0);
    check_eq("rstmid we",   32'(o.we),   32'd0);
    check_eq("rstmid spout", 32'(o.spout), 32'd0);
    o = sample(3);
    check_eq("rstmid L3 ret", 32'(o.ret), 32'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      o = sample(1);
      check_eq($sformatf("rstmid after%0d done", i), 32'(o.done), 32'd0);
      check_eq($sformatf("rstmid after%0d we", i),   32'(o.we),   32'd0);
    end
  endtask

  initial begin
    int          lat;
    int          kind;
    logic [15:0] sp;
    obs_t        o;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    rst = 1'b1;
    drive(1, 1'b0, '0);
    drive(3, 1'b0, '0);
    last_ret[0] = '0;
    last_ret[1] = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_state(1);
    check_reset_state(3);

    // Nominal, underflow, exact-boundary accept.
    mem[16'h0103] = 8'h12;
    mem[16'h0102] = 8'h34;
    pop(1, 16'h0103, 1'b0, 1'b0);
    pop(1, 16'h0101, 1'b0, 1'b0);
    mem[16'h0102] = 8'hAB;
    mem[16'h0101] = 8'hCD;
    pop(1, 16'h0102, 1'b0, 1'b0);

    // Start held through a whole pop: ignored while busy, accepted after Done.
    mem[16'h0102] = 8'h34;
    mem[16'h0200] = 8'(($urandom));
    mem[16'h01FF] = 8'(($urandom));
    pop(1, 16'h0103, 1'b1, 1'b0);
    pop(1, 16'h0200, 1'b0, 1'b1);

    pop(3, 16'h0103, 1'b0, 1'b0);
    reset_mid_pop();

    for (int n = 0; n < 40; n++) begin
      lat  = ($urandom_range(0, 1) == 0) ? 1 : 3;
      kind = int'($urandom_range(0, 3));
      if (kind == 0)      sp = BASE + 16'($urandom_range(0, 3));
      else if (kind == 1) sp = 16'($urandom_range(0, 16'h00FF));
      else                sp = 16'($urandom);
      mem[sp]         = 8'($urandom);
      mem[sp - 16'd1] = 8'($urandom);
      pop(lat, sp, 1'b0, 1'b0);
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        o = sample(lat);
        check_eq($sformatf("rand%0d gap done", n), 32'(o.done), 32'd0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
